// File: rtl/timer_register.sv
// -----------------------------------------------------------------------------
// timer_register
//   Register file of the 64-bit timer. It decodes single-cycle wr_en/rd_en
//   accesses, holds the control (TCR), compare (TCMP0/1), interrupt-enable
//   (TIER) and halt-request (THCSR) registers, and returns registered read
//   data. It also issues one-cycle commands to the counter and interrupt
//   logic: counter clear, counter word write and interrupt clear.
//
//   Build option: define REG_ERROR_CHECK_EN to enable illegal TCR-write
//   detection (reg_error_flag) and blocking of the offending write.
//   Without it reg_error_flag is tied low and TCR writes always land.
//
//   Address map (byte addresses, 12 bits):
//     000 TCR   : [0] timer_en, [1] div_en, [11:8] div_val
//     004 TDR0  : counter[31:0]  (write goes to the counter)
//     008 TDR1  : counter[63:32] (write goes to the counter)
//     00C TCMP0 : compare[31:0]
//     010 TCMP1 : compare[63:32]
//     014 TIER  : [0] interrupt_en
//     018 TISR  : [0] interrupt_status (RO, W1C)
//     01C THCSR : [0] halt_req (RW), [1] halt_ack (RO)
// -----------------------------------------------------------------------------
module timer_register (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  input  logic [3:0]  tim_pstrb,
  output logic [31:0] tim_prdata,
  input  logic [63:0] cnt_val,
  input  logic        halt_ack_status,
  input  logic        interrupt_status,
  output logic        timer_en,
  output logic        div_en,
  output logic [3:0]  div_val,
  output logic        halt_req,
  output logic [63:0] compare_val,
  output logic        interrupt_en,
  output logic        counter_clear,
  output logic [1:0]  counter_write_sel,
  output logic [31:0] counter_write_data,
  output logic        interrupt_clear,
  output logic        reg_error_flag
);

  localparam logic [11:0] ADDR_TCR   = 12'h000;
  localparam logic [11:0] ADDR_TDR0  = 12'h004;
  localparam logic [11:0] ADDR_TDR1  = 12'h008;
  localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
  localparam logic [11:0] ADDR_TCMP1 = 12'h010;
  localparam logic [11:0] ADDR_TIER  = 12'h014;
  localparam logic [11:0] ADDR_TISR  = 12'h018;
  localparam logic [11:0] ADDR_THCSR = 12'h01C;

  localparam logic [3:0]  DIV_VAL_RST = 4'd1;
  localparam logic [3:0]  DIV_VAL_MAX = 4'd8;

  localparam logic [1:0]  CNT_WR_IDLE = 2'b00;
  localparam logic [1:0]  CNT_WR_LO   = 2'b01;
  localparam logic [1:0]  CNT_WR_HI   = 2'b10;

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic wr_tcr, wr_tdr0, wr_tdr1, wr_tcmp0, wr_tcmp1, wr_tier, wr_thcsr;

  assign wr_tcr   = wr_en && (tim_paddr == ADDR_TCR);
  assign wr_tdr0  = wr_en && (tim_paddr == ADDR_TDR0);
  assign wr_tdr1  = wr_en && (tim_paddr == ADDR_TDR1);
  assign wr_tcmp0 = wr_en && (tim_paddr == ADDR_TCMP0);
  assign wr_tcmp1 = wr_en && (tim_paddr == ADDR_TCMP1);
  assign wr_tier  = wr_en && (tim_paddr == ADDR_TIER);
  assign wr_thcsr = wr_en && (tim_paddr == ADDR_THCSR);

  // ---------------------------------------------------------------------------
  // TCR write candidate: written bytes replace fields, unwritten ones keep
  // their current value. Only the implemented fields are materialised.
  // ---------------------------------------------------------------------------
  logic       new_timer_en;
  logic       new_div_en;
  logic [3:0] new_div_val;
  logic       tcr_err;
  logic       tcr_ok;

  assign new_timer_en = tim_pstrb[0] ? tim_pwdata[0]    : timer_en;
  assign new_div_en   = tim_pstrb[0] ? tim_pwdata[1]    : div_en;
  assign new_div_val  = tim_pstrb[1] ? tim_pwdata[11:8] : div_val;

`ifdef REG_ERROR_CHECK_EN
  // Divider settings are frozen while the timer runs, and div_val is capped.
  assign tcr_err = wr_tcr &&
                   ((timer_en && ((new_div_en != div_en) || (new_div_val != div_val))) ||
                    (new_div_val > DIV_VAL_MAX));
`else
  // Without error checking every TCR write is accepted as-is.
  assign tcr_err = 1'b0;
`endif

  assign tcr_ok         = wr_tcr && !tcr_err;
  assign reg_error_flag = tcr_err;

  // ---------------------------------------------------------------------------
  // One-cycle commands, valid during the write cycle
  // ---------------------------------------------------------------------------
  assign counter_clear   = tcr_ok && timer_en && !new_timer_en;
  assign interrupt_clear = wr_en && (tim_paddr == ADDR_TISR) && tim_pstrb[0] && tim_pwdata[0];

  // Counter word write: unstrobed bytes are refilled from the live count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    counter_write_sel  = CNT_WR_IDLE;
    counter_write_data = '0;
    if (wr_tdr0) begin
      counter_write_sel  = CNT_WR_LO;
      counter_write_data = byte_merge(cnt_val[31:0], tim_pwdata, tim_pstrb);
    end else if (wr_tdr1) begin
      counter_write_sel  = CNT_WR_HI;
      counter_write_data = byte_merge(cnt_val[63:32], tim_pwdata, tim_pstrb);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // TCR: enables and divider, updated only by an accepted write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: control registers reset asynchronously so the timer is quiescent
    // the moment reset asserts, even in the middle of an access.
    if (!sys_rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= DIV_VAL_RST;
    end else if (tcr_ok) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      timer_en <= new_timer_en;
      div_en   <= new_div_en;
      div_val  <= new_div_val;
    end
  end

  // TCMP0/TCMP1: 64-bit compare value, byte-writable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      compare_val <= '1;
    end else begin
      if (wr_tcmp0) compare_val[31:0]  <= byte_merge(compare_val[31:0],  tim_pwdata, tim_pstrb);
      if (wr_tcmp1) compare_val[63:32] <= byte_merge(compare_val[63:32], tim_pwdata, tim_pstrb);
    end
  end

  // TIER and THCSR single-bit controls, both in byte 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      interrupt_en <= 1'b0;
      halt_req     <= 1'b0;
    end else begin
      if (wr_tier  && tim_pstrb[0]) interrupt_en <= tim_pwdata[0];
      if (wr_thcsr && tim_pstrb[0]) halt_req     <= tim_pwdata[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  // Read multiplexer; reserved bits and unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    unique case (tim_paddr)
      ADDR_TCR:   rd_mux = {20'd0, div_val, 6'd0, div_en, timer_en};
      ADDR_TDR0:  rd_mux = cnt_val[31:0];
      ADDR_TDR1:  rd_mux = cnt_val[63:32];
      ADDR_TCMP0: rd_mux = compare_val[31:0];
      ADDR_TCMP1: rd_mux = compare_val[63:32];
      ADDR_TIER:  rd_mux = {31'd0, interrupt_en};
      ADDR_TISR:  rd_mux = {31'd0, interrupt_status};
      ADDR_THCSR: rd_mux = {30'd0, halt_ack_status, halt_req};
      default:    rd_mux = '0;
    endcase
  end

  // Read data register: captured on a read, held until the next read. A
  // simultaneous write lands on the same edge, so the read sees the old value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tim_prdata <= '0;
    end else if (rd_en) begin
      tim_prdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_timer_register.sv
// -----------------------------------------------------------------------------
// tb_timer_register
//   Self-checking bench for timer_register. A word-level register model is
//   updated once per cycle; one compare process checks every DUT output
//   against it on each falling edge. Directed steps pin the model with
//   literal expectations, then randomized traffic runs against the model.
//   Build with +define+REG_ERROR_CHECK_EN to exercise the error checks.
// -----------------------------------------------------------------------------
module tb_timer_register;

`ifdef REG_ERROR_CHECK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wr_en, rd_en;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic [63:0] cnt_val;
  logic        halt_ack_status, interrupt_status;
  logic        timer_en, div_en, halt_req, interrupt_en;
  logic [3:0]  div_val;
  logic [63:0] compare_val;
  logic        counter_clear, interrupt_clear, reg_error_flag;
  logic [1:0]  counter_write_sel;
  logic [31:0] counter_write_data;

  int n_cmp = 0;
  int n_bad = 0;

  timer_register dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .wr_en              (wr_en),
    .rd_en              (rd_en),
    .tim_paddr          (tim_paddr),
    .tim_pwdata         (tim_pwdata),
    .tim_pstrb          (tim_pstrb),
    .tim_prdata         (tim_prdata),
    .cnt_val            (cnt_val),
    .halt_ack_status    (halt_ack_status),
    .interrupt_status   (interrupt_status),
    .timer_en           (timer_en),
    .div_en             (div_en),
    .div_val            (div_val),
    .halt_req           (halt_req),
    .compare_val        (compare_val),
    .interrupt_en       (interrupt_en),
    .counter_clear      (counter_clear),
    .counter_write_sel  (counter_write_sel),
    .counter_write_data (counter_write_data),
    .interrupt_clear    (interrupt_clear),
    .reg_error_flag     (reg_error_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: registers held as the words software would read back.
  // ---------------------------------------------------------------------------
  logic [31:0] m_tcr, m_tcmp0, m_tcmp1, m_tier, m_thcsr_rw, m_prdata;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h000: return m_tcr;
      12'h004: return cnt_val[31:0];
      12'h008: return cnt_val[63:32];
      12'h00C: return m_tcmp0;
      12'h010: return m_tcmp1;
      12'h014: return m_tier;
      12'h018: return {31'd0, interrupt_status};
      12'h01C: return m_thcsr_rw | {30'd0, halt_ack_status, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // Single compare process: check everything, then advance the model by the
  // access that the coming rising edge will perform.
  always @(negedge sys_clk) begin
    logic [31:0] nw;
    logic        e_err, e_cc, e_ic;
    logic [1:0]  e_sel;
    logic [31:0] e_wd;
    if (!sys_rst_n) begin
      m_tcr = 32'h0000_0100; m_tcmp0 = '1; m_tcmp1 = '1;
      m_tier = 0; m_thcsr_rw = 0; m_prdata = 0;
    end
    check("timer_en",     timer_en,     m_tcr[0]);
    check("div_en",       div_en,       m_tcr[1]);
    check("div_val",      div_val,      m_tcr[11:8]);
    check("compare_val",  compare_val,  {m_tcmp1, m_tcmp0});
    check("interrupt_en", interrupt_en, m_tier[0]);
    check("halt_req",     halt_req,     m_thcsr_rw[0]);
    check("prdata",       tim_prdata,   m_prdata);
    if (sys_rst_n) begin
      nw    = merge(m_tcr, tim_pwdata, tim_pstrb) & 32'h0000_0F03;
      e_err = ERR_CHK && wr_en && tim_paddr == 12'h000 &&
              ((m_tcr[0] && ((nw & 32'hF02) != (m_tcr & 32'hF02))) || nw[11:8] > 8);
      e_cc  = wr_en && tim_paddr == 12'h000 && !e_err && m_tcr[0] && !nw[0];
      e_ic  = wr_en && tim_paddr == 12'h018 && tim_pstrb[0] && tim_pwdata[0];
      e_sel = 2'b00;
      e_wd  = 32'd0;
      if (wr_en && tim_paddr == 12'h004) begin
        e_sel = 2'b01; e_wd = merge(cnt_val[31:0], tim_pwdata, tim_pstrb);
      end
      if (wr_en && tim_paddr == 12'h008) begin
        e_sel = 2'b10; e_wd = merge(cnt_val[63:32], tim_pwdata, tim_pstrb);
      end
      check("reg_error_flag",     reg_error_flag,     e_err);
      check("counter_clear",      counter_clear,      e_cc);
      check("interrupt_clear",    interrupt_clear,    e_ic);
      check("counter_write_sel",  counter_write_sel,  e_sel);
      check("counter_write_data", counter_write_data, e_wd);
      // Read sees pre-write state, so capture it before applying the write.
      if (rd_en) m_prdata = model_read(tim_paddr);
      if (wr_en) begin
        case (tim_paddr)
          12'h000: if (!e_err) m_tcr = nw;
          12'h00C: m_tcmp0 = merge(m_tcmp0, tim_pwdata, tim_pstrb);
          12'h010: m_tcmp1 = merge(m_tcmp1, tim_pwdata, tim_pstrb);
          12'h014: m_tier = merge(m_tier, tim_pwdata, tim_pstrb) & 32'h1;
          12'h01C: m_thcsr_rw = merge(m_thcsr_rw, tim_pwdata, tim_pstrb) & 32'h1;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic w, input logic r, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(posedge sys_clk); #1;
    wr_en = w; rd_en = r; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h000, 32'd0, 4'h0);
  endtask

  task automatic at_sample();
    @(negedge sys_clk); #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    wr_en = 0; rd_en = 0; tim_paddr = 0; tim_pwdata = 0; tim_pstrb = 0;
    cnt_val = 0; halt_ack_status = 0; interrupt_status = 0;

    // Reset values
    at_sample();
    check("rst div_val", div_val, 64'd1);
    check("rst timer_en", timer_en, 64'd0);
    check("rst compare", compare_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst prdata", tim_prdata, 64'd0);
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;

    // Compare register write then read back
    drive(1, 0, 12'h00C, 32'h1234_5678, 4'hF);
    drive(0, 1, 12'h00C, 32'd0, 4'h0);
    idle(); at_sample();
    check("tcmp0 readback", tim_prdata, 64'h1234_5678);

    // Counter word reads
    cnt_val = 64'hAAAA_BBBB_C0C0_DADA;
    drive(0, 1, 12'h004, 32'd0, 4'h0);
    drive(0, 1, 12'h008, 32'd0, 4'h0);
    at_sample(); check("tdr0 read", tim_prdata, 64'hC0C0_DADA);
    idle(); at_sample(); check("tdr1 read", tim_prdata, 64'hAAAA_BBBB);

    // Counter low-word write merges unstrobed bytes from the live count
    drive(1, 0, 12'h004, 32'h1122_3344, 4'b0101);
    at_sample();
    check("tdr0 wr sel", counter_write_sel, 64'h1);
    check("tdr0 wr data", counter_write_data, 64'hC022_DA44);

    // Interrupt clear pulse
    drive(1, 0, 12'h018, 32'h1, 4'h1);
    at_sample(); check("int_clear pulse", interrupt_clear, 64'd1);
    idle(); at_sample(); check("int_clear idle", interrupt_clear, 64'd0);

    // div_val boundary: 8 legal, 9 rejected only with error checking
    drive(1, 0, 12'h000, 32'h800, 4'hF);
    at_sample(); check("div8 err", reg_error_flag, 64'd0);
    idle(); at_sample(); check("div8 val", div_val, 64'd8);
    drive(1, 0, 12'h000, 32'h900, 4'hF);
    at_sample(); check("div9 err", reg_error_flag, ERR_CHK ? 64'd1 : 64'd0);
    idle(); at_sample(); check("div9 val", div_val, ERR_CHK ? 64'd8 : 64'd9);

    // Enable timer with divider
    drive(1, 0, 12'h000, 32'h503, 4'hF);
    at_sample(); check("tcr503 err", reg_error_flag, 64'd0);
    idle(); at_sample();
    check("tcr503 timer_en", timer_en, 64'd1);
    check("tcr503 div_en", div_en, 64'd1);
    check("tcr503 div_val", div_val, 64'd5);

    // Divider change while running
    drive(1, 0, 12'h000, 32'h603, 4'hF);
    at_sample(); check("tcr603 err", reg_error_flag, ERR_CHK ? 64'd1 : 64'd0);
    idle(); at_sample(); check("tcr603 div_val", div_val, ERR_CHK ? 64'd5 : 64'd6);

    // Stop the timer touching only byte 0 (div_en kept at 1)
    drive(1, 0, 12'h000, 32'h2, 4'h1);
    at_sample(); check("stop counter_clear", counter_clear, 64'd1);
    idle(); at_sample();
    check("stop timer_en", timer_en, 64'd0);
    check("stop clear idle", counter_clear, 64'd0);

    // Zero strobes change nothing
    drive(1, 0, 12'h014, 32'h1, 4'h0);
    idle(); at_sample(); check("tier strb0", interrupt_en, 64'd0);

    // Simultaneous write and read: read returns the pre-write value
    drive(1, 1, 12'h00C, 32'h0, 4'hF);
    idle(); at_sample();
    check("wr+rd prdata", tim_prdata, 64'h1234_5678);
    check("wr+rd tcmp0", compare_val[31:0], 64'd0);

    // Unmapped address reads zero
    drive(1, 0, 12'h020, 32'hFFFF_FFFF, 4'hF);
    drive(0, 1, 12'h020, 32'd0, 4'h0);
    idle(); at_sample(); check("unmapped read", tim_prdata, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [31:0] d;
      @(posedge sys_clk); #1;
      sel = $urandom_range(0, 9);
      wr_en = ($urandom_range(0, 2) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      tim_paddr = (sel < 8) ? 12'(sel * 4) : 12'($urandom);
      d = $urandom;
      if (tim_paddr == 12'h000 && $urandom_range(0, 3) != 0) d[11:8] = 4'($urandom_range(0, 9));
      tim_pwdata = d;
      tim_pstrb = 4'($urandom);
      cnt_val = {$urandom, $urandom};
      halt_ack_status = 1'($urandom);
      interrupt_status = 1'($urandom);
    end

    // Reset in the middle of a write aborts it
    drive(1, 1, 12'h00C, 32'hDEAD_BEEF, 4'hF);
    #2 sys_rst_n = 1'b0;
    #1 check("midrst compare", compare_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("midrst prdata", tim_prdata, 64'd0);
    @(posedge sys_clk); #1;
    wr_en = 0; rd_en = 0; sys_rst_n = 1'b1;
    idle(); at_sample();
    check("post-rst compare", compare_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("post-rst div_val", div_val, 64'd1);

    repeat (2) @(posedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
